// File: rtl/sram_row_ctrl.sv
// Row access controller for the SRAM memcell array: one-hot row decode and a
// WE pulse framed by setup/hold cycles. Define SRAM_ROW_CTRL_WRITE_VERIFY_EN to read back every write.
module sram_row_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  output logic [(2**ADDR_W)-1:0]  Row_select,
  output logic                    Write_enable,
  output logic [DATA_W-1:0]       mem_data_in,
  input  logic [DATA_W-1:0]       mem_data_out
);
  localparam int ROWS = 2**ADDR_W;

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, VSETUP, VREAD} state_t;

  state_t              state, nxt;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic                accept;
`ifdef SRAM_ROW_CTRL_WRITE_VERIFY_EN
  logic [DATA_W-1:0]   wdata_q;
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign addr_n    = accept ? req_addr : addr_q;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (req_valid) nxt = SETUP;
      SETUP:  nxt = wr_q ? WRITE : READ;
      WRITE:  nxt = HOLD;
`ifdef SRAM_ROW_CTRL_WRITE_VERIFY_EN
      HOLD:   nxt = VSETUP;
      VSETUP: nxt = VREAD;
      VREAD:  nxt = IDLE;
`else
      HOLD:   nxt = IDLE;
`endif
      READ:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      Row_select   <= '0;
      Write_enable <= 1'b0;
      mem_data_in  <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
`ifdef SRAM_ROW_CTRL_WRITE_VERIFY_EN
      wdata_q      <= '0;
`endif
    end else begin
      state      <= nxt;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      // Array-side outputs are registered from the next state so they change
      // on the same edge as the state; WE only rises strictly inside a row window.
      Row_select   <= (nxt == IDLE) ? '0 : (ROWS'(1) << addr_n);
      Write_enable <= (nxt == WRITE);
      if (accept) begin
        wr_q   <= req_write;
        addr_q <= req_addr;
        if (req_write) mem_data_in <= req_wdata;
`ifdef SRAM_ROW_CTRL_WRITE_VERIFY_EN
        wdata_q <= req_wdata;
`endif
      end
      case (state)
        READ: begin
          resp_valid <= 1'b1;
          resp_rdata <= mem_data_out;
        end
`ifdef SRAM_ROW_CTRL_WRITE_VERIFY_EN
        VREAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= mem_data_out;
          resp_err   <= (mem_data_out != wdata_q);
        end
`else
        HOLD: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
